// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants: clock division, BCD limits and
// the control-block state encoding used alongside the counter.
package stopwatch_pkg;

    localparam int unsigned DEF_CLK_FREQ_HZ = 100_000_000;
    localparam int unsigned DEF_TICK_HZ     = 100;
    localparam int unsigned NUM_DIGITS      = 4;
    localparam logic [3:0]  BCD_MAX         = 4'd9;

    typedef enum logic [1:0] {
        CTL_IDLE,
        CTL_RUN,
        CTL_PAUSE
    } ctl_state_e;

    function automatic int unsigned calc_div(
        input int unsigned clk_hz,
        input int unsigned tick_hz
    );
        return clk_hz / tick_hz;
    endfunction

    localparam int unsigned DIV = calc_div(DEF_CLK_FREQ_HZ, DEF_TICK_HZ);

endpackage

// File: rtl/time_counter_bcd_digit.sv
// One decimal digit of the stopwatch; rolls 9 -> 0 and
// passes a carry to the next digit in the chain.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       carry_in,
    output logic [3:0] value,
    output logic       carry_out
);

    logic [3:0] value_q;
    logic [3:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = 4'd0;
        end else if (carry_in) begin
            value_d = (value_q == BCD_MAX) ? 4'd0 : value_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value     = value_q;
    assign carry_out = carry_in && (value_q == BCD_MAX);

endmodule

// File: rtl/time_counter.sv
// Stopwatch time base: prescaler feeding a 4-digit BCD chain
// (SS.hh) with a one-cycle pulse on 99.99 -> 00.00.
module time_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int unsigned TICK_HZ     = DEF_TICK_HZ
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_regs,
    input  logic       count_enabled,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic       wrapped
);

    localparam int unsigned DIV_L = calc_div(CLK_FREQ_HZ, TICK_HZ);
    localparam int unsigned PW    = $clog2(DIV_L);
    localparam logic [PW-1:0] PS_MAX = PW'(DIV_L - 1);

    logic [PW-1:0] ps_q;
    logic [PW-1:0] ps_d;
    logic          tick;
    logic          wrapped_q;
    logic          wrapped_d;

    logic [NUM_DIGITS-1:0][3:0] digits;
    logic [NUM_DIGITS:0]        carry;

    // Pausing keeps the partial prescale count, so no tick is lost.
    always_comb begin
        ps_d = ps_q;
        tick = 1'b0;
        if (init_regs) begin
            ps_d = '0;
        end else if (count_enabled) begin
            if (ps_q == PS_MAX) begin
                ps_d = '0;
                tick = 1'b1;
            end else begin
                ps_d = ps_q + 1'b1;
            end
        end
    end

    assign carry[0]  = tick;
    assign wrapped_d = carry[NUM_DIGITS] && !init_regs;

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q      <= '0;
            wrapped_q <= 1'b0;
        end else begin
            ps_q      <= ps_d;
            wrapped_q <= wrapped_d;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        bcd_digit u_digit (
            .clk       (clk),
            .reset     (reset),
            .clear     (init_regs),
            .carry_in  (carry[i]),
            .value     (digits[i]),
            .carry_out (carry[i+1])
        );
    end

    assign dig0    = digits[0];
    assign dig1    = digits[1];
    assign dig2    = digits[2];
    assign dig3    = digits[3];
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_time_counter.sv
// Scoreboarded bench for time_counter with DIV = 4; an integer
// time model predicts every cycle plus directed scenario checks.
module tb_time_counter;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       init_regs = 1'b0;
    logic       count_enabled = 1'b0;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic       wrapped;

    int n_cmp = 0;
    int n_err = 0;

    int m_ps = 0;
    int m_t  = 0;
    int m_w  = 0;

    logic [16:0] sb_q[$];

    time_counter #(
        .CLK_FREQ_HZ (4),
        .TICK_HZ     (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .init_regs     (init_regs),
        .count_enabled (count_enabled),
        .dig0          (dig0),
        .dig1          (dig1),
        .dig2          (dig2),
        .dig3          (dig3),
        .wrapped       (wrapped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] model_out();
        logic [16:0] v;
        v[16:13] = 4'((m_t / 1000) % 10);
        v[12:9]  = 4'((m_t / 100) % 10);
        v[8:5]   = 4'((m_t / 10) % 10);
        v[4:1]   = 4'(m_t % 10);
        v[0]     = m_w[0];
        return v;
    endfunction

    task automatic step(input logic r, input logic in, input logic en);
        logic [16:0] exp;
        logic [16:0] got;
        reset = r;
        init_regs = in;
        count_enabled = en;
        if (r || in) begin
            m_ps = 0;
            m_t  = 0;
            m_w  = 0;
        end else if (en) begin
            if (m_ps == DIV - 1) begin
                m_ps = 0;
                m_w  = (m_t == 9999) ? 1 : 0;
                m_t  = (m_t + 1) % 10000;
            end else begin
                m_ps++;
                m_w = 0;
            end
        end else begin
            m_w = 0;
        end
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        got = {dig3, dig2, dig1, dig0, wrapped};
        chk("sb", 32'(got), 32'(exp));
    endtask

    task automatic run(input int n, input logic en);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, en);
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 1'b0);
        chk("rst_time", {dig3, dig2, dig1, dig0}, 16'h0000);
        chk("rst_wrap", wrapped, 1'b0);

        // First tick after DIV enabled cycles, tenths after 40
        run(3, 1'b1);
        chk("first_pre", dig0, 4'd0);
        run(1, 1'b1);
        chk("first_d0", {dig3, dig2, dig1, dig0}, 16'h0001);
        run(36, 1'b1);
        chk("ten_ticks", {dig3, dig2, dig1, dig0}, 16'h0010);

        // Pause mid-prescale keeps the partial count
        step(1'b0, 1'b1, 1'b0);
        run(2, 1'b1);
        run(5, 1'b0);
        run(1, 1'b1);
        chk("pause_3rd", dig0, 4'd0);
        run(1, 1'b1);
        chk("pause_4th", dig0, 4'd1);

        // Carry across two digits
        step(1'b0, 1'b1, 1'b0);
        run(1596, 1'b1);
        chk("t03_99", {dig3, dig2, dig1, dig0}, 16'h0399);
        run(4, 1'b1);
        chk("t04_00", {dig3, dig2, dig1, dig0}, 16'h0400);

        // Full wrap
        step(1'b0, 1'b1, 1'b0);
        run(39996, 1'b1);
        chk("t99_99", {dig3, dig2, dig1, dig0}, 16'h9999);
        chk("no_wrap", wrapped, 1'b0);
        run(3, 1'b1);
        chk("pre_wrap", wrapped, 1'b0);
        run(1, 1'b1);
        chk("wrap_time", {dig3, dig2, dig1, dig0}, 16'h0000);
        chk("wrap_pulse", wrapped, 1'b1);
        run(1, 1'b1);
        chk("wrap_end", wrapped, 1'b0);
        run(3, 1'b1);
        chk("post_wrap", dig0, 4'd1);

        // init_regs wins over count_enabled and clears prescaler
        step(1'b0, 1'b1, 1'b0);
        run(30, 1'b1);
        chk("t00_07", {dig3, dig2, dig1, dig0}, 16'h0007);
        step(1'b0, 1'b1, 1'b1);
        chk("init_clr", {dig3, dig2, dig1, dig0}, 16'h0000);
        run(3, 1'b1);
        chk("init_pre", dig0, 4'd0);
        run(1, 1'b1);
        chk("init_tick", dig0, 4'd1);

        // Reset mid-prescale at 12.34, held with enable/init high
        step(1'b0, 1'b1, 1'b0);
        run(4936, 1'b1);
        chk("t12_34", {dig3, dig2, dig1, dig0}, 16'h1234);
        run(2, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("rst_mid", {dig3, dig2, dig1, dig0}, 16'h0000);
        chk("rst_mid_w", wrapped, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("rst_held", {dig3, dig2, dig1, dig0}, 16'h0000);
        run(3, 1'b1);
        chk("rst_pre", dig0, 4'd0);
        run(1, 1'b1);
        chk("rst_resume", dig0, 4'd1);

        // Random enable pattern against the model
        for (int i = 0; i < 400; i++) begin
            step(1'b0, ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100000000, input clock frequency.
REQ-002 Parameter TICK_HZ, default 100, count rate (hundredths of a second); DIV = CLK_FREQ_HZ/TICK_HZ, required integer >= 2.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 init_regs  input  1  from upstream control; clear time to 00.00 while high.
REQ-006 count_enabled  input  1  from upstream control; advance time while high.
REQ-007 dig0  output  4  BCD hundredths of a second, 0..9.
REQ-008 dig1  output  4  BCD tenths of a second, 0..9.
REQ-009 dig2  output  4  BCD seconds ones, 0..9.
REQ-010 dig3  output  4  BCD seconds tens, 0..9.
REQ-011 wrapped  output  1  one-cycle pulse when time rolls 99.99 -> 00.00.

Function
REQ-012 Prescaler counter, width ceil(log2(DIV)), counts 0..DIV-1.
REQ-013 Priority per edge: reset > init_regs > count_enabled > hold.
REQ-014 init_regs=1: prescaler, dig0..dig3 -> 0, wrapped -> 0, regardless of count_enabled.
REQ-015 count_enabled=1, init_regs=0: prescaler +1; at DIV-1 it returns to 0 and an internal tick is asserted in that same cycle.
REQ-016 count_enabled=0, init_regs=0: prescaler and all digits hold value (pause keeps partial prescale count).
REQ-017 Tick increments the 4-digit BCD value on the same edge the prescaler returns to 0; first increment occurs DIV enabled cycles after clear.
REQ-018 Digit cascade: digit at 9 with carry-in -> 0 and carry-out; otherwise +1 and no carry-out; dig0 carry-in = tick.
REQ-019 dig3 at 9 with carry-in -> 0; value 99.99 + tick -> 00.00.
REQ-020 wrapped = 1 for exactly the cycle following the 99.99 -> 00.00 edge; 0 otherwise; counting continues after wrap.
REQ-021 Digits never take values 10..15; outputs are registered, no combinational input-to-output path.
REQ-022 count_enabled toggling mid-prescale: no tick lost or duplicated; total ticks = floor(total enabled cycles since clear / DIV).

Reset
REQ-023 reset=1 at rising edge: prescaler=0, dig0..dig3=0, wrapped=0, next cycle.
REQ-024 reset mid-count or concurrent with init_regs/count_enabled: reset result only; counting resumes from 0 only after reset deasserts.

Structure
REQ-025 DIV and BCD digit max (9) constants in shared stopwatch package alongside control-block constants.
REQ-026 One sub-module bcd_digit (clk, reset, clear, carry_in, value[3:0], carry_out), instantiated four times in a carry chain.
REQ-027 Prescaler and wrapped-pulse register reside in time_counter top.

Verification (bench uses CLK_FREQ_HZ=4, TICK_HZ=1 -> DIV=4, 10 ns clock)
REQ-028 reset 1 cycle, then init_regs=0, count_enabled=1 for 4 cycles -> dig0=1, others 0; after 40 cycles -> dig1=1, dig0=0.
REQ-029 Enable 2 cycles, disable 5 cycles, enable 2 cycles -> dig0 increments exactly once, on the 4th enabled cycle.
REQ-030 Enable 399 ticks (1596 cycles) -> 03.99; one more tick -> 04.00 (dig0,dig1 reset, dig2=4).
REQ-031 Enable 9999 ticks -> 99.99, wrapped=0; next tick -> 00.00 and wrapped=1 for exactly one cycle.
REQ-032 Count to 00.07, assert init_regs with count_enabled=1 -> next cycle 00.00, prescaler 0; deassert -> first tick 4 cycles later.
REQ-033 Reset asserted mid-prescale at 12.34 -> next cycle 00.00, wrapped=0; reset held 3 cycles with count_enabled=1 -> digits stay 0.
